// File: rtl/jk_ff_monitor.sv
// jk_ff_monitor: passive response checker for a single jk_ff instance.
// Holds a golden JK model of the observed flop, compares q/qbar against it
// on every clock edge while checking, and reports a registered error pulse,
// a sticky fail flag, the first error code and saturating cycle/error counters.
// The monitor only observes; nothing here drives the flop under check.
module jk_ff_monitor #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             dut_clr,
    input  logic             dut_preset,
    input  logic             q,
    input  logic             qbar,
    output logic             model_q,
    output logic             model_vld,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [1:0]       first_code,
    output logic             fail,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_CHECK = 2'b10,
        ST_FAIL  = 2'b11
    } state_t;

    // Golden flop next state: clear beats preset, then the JK table.
    function automatic logic jk_next(input logic cur, input logic jj, input logic kk,
                                     input logic dclr, input logic dpre);
        logic nxt;
        if (!dclr) begin
            nxt = 1'b0;
        end else if (!dpre) begin
            nxt = 1'b1;
        end else begin
            case ({jj, kk})
                2'b00:   nxt = cur;
                2'b01:   nxt = 1'b0;
                2'b10:   nxt = 1'b1;
                2'b11:   nxt = ~cur;
                default: nxt = cur;
            endcase
        end
        return nxt;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic             model_q_r, model_q_nxt_s;
    logic             model_vld_r, model_vld_nxt_s;
    logic             err_r, err_nxt_s;
    logic [1:0]       err_code_r, err_code_nxt_s;
    logic [1:0]       first_code_r, first_code_nxt_s;
    logic             fail_r, fail_nxt_s;
    logic [CNT_W-1:0] chk_cnt_r, chk_cnt_nxt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;
    logic             exp_q_s;
    logic [1:0]       code_s;
    logic             model_step_s;

    // Expected q this edge: async forces of the checked flop act immediately,
    // otherwise the flop must still show what the model registered last edge.
    always_comb begin
        exp_q_s      = model_q_r;
        model_step_s = jk_next(model_q_r, j, k, dut_clr, dut_preset);
        if (!dut_clr) begin
            exp_q_s = 1'b0;
        end else if (!dut_preset) begin
            exp_q_s = 1'b1;
        end else begin
            exp_q_s = model_q_r;
        end
        code_s = {(qbar != ~q), (q != exp_q_s)};
    end

    // FSM next state and next values of every status register.
    always_comb begin
        state_nxt_s      = state_r;
        model_q_nxt_s    = model_q_r;
        model_vld_nxt_s  = model_vld_r;
        err_nxt_s        = 1'b0;
        err_code_nxt_s   = 2'b00;
        first_code_nxt_s = first_code_r;
        fail_nxt_s       = fail_r;
        chk_cnt_nxt_s    = chk_cnt_r;
        err_cnt_nxt_s    = err_cnt_r;
        case (state_r)
            ST_IDLE: begin
                model_vld_nxt_s = 1'b0;
                if (en) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (!en) begin
                    state_nxt_s     = ST_IDLE;
                    model_vld_nxt_s = 1'b0;
                end else if (!dut_clr || !dut_preset) begin
                    // A forced reset/preset is the first point the flop state is known.
                    state_nxt_s     = ST_CHECK;
                    model_q_nxt_s   = model_step_s;
                    model_vld_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    state_nxt_s     = ST_IDLE;
                    model_vld_nxt_s = 1'b0;
                end else begin
                    model_q_nxt_s = model_step_s;
                    chk_cnt_nxt_s = sat_inc(chk_cnt_r);
                    if (code_s != 2'b00) begin
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = code_s;
                        err_cnt_nxt_s  = sat_inc(err_cnt_r);
                        fail_nxt_s     = 1'b1;
                        if (!fail_r) begin
                            first_code_nxt_s = code_s;
                        end else begin
                            first_code_nxt_s = first_code_r;
                        end
                        if (STOP_ON_ERR) begin
                            state_nxt_s = ST_FAIL;
                        end else begin
                            state_nxt_s = ST_CHECK;
                        end
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end
            end
            ST_FAIL: begin
                // Everything frozen; only the monitor reset leaves this state.
                state_nxt_s = ST_FAIL;
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                model_vld_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Model, error and counter registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            model_q_r    <= 1'b0;
            model_vld_r  <= 1'b0;
            err_r        <= 1'b0;
            err_code_r   <= 2'b00;
            first_code_r <= 2'b00;
            fail_r       <= 1'b0;
            chk_cnt_r    <= {CNT_W{1'b0}};
            err_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            model_q_r    <= model_q_nxt_s;
            model_vld_r  <= model_vld_nxt_s;
            err_r        <= err_nxt_s;
            err_code_r   <= err_code_nxt_s;
            first_code_r <= first_code_nxt_s;
            fail_r       <= fail_nxt_s;
            chk_cnt_r    <= chk_cnt_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
        end
    end

    assign model_q    = model_q_r;
    assign model_vld  = model_vld_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign first_code = first_code_r;
    assign fail       = fail_r;
    assign chk_cnt    = chk_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign state      = state_r;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Scoreboard bench for jk_ff_monitor. Three instances share one set of
// observed-flop stimulus: default parameters, STOP_ON_ERR=1, and CNT_W=3.
// Each stimulus step pushes the hand-computed post-edge outputs of one
// instance; a monitor process pops and compares after every clock edge.
module tb_jk_ff_monitor;

    logic clk, clr, en, j, k, dut_clr, dut_preset, q, qbar;

    logic       a_mq, a_mv, a_err, a_fail;
    logic [1:0] a_ec, a_fc, a_st;
    logic [7:0] a_cc, a_ecnt;
    logic       b_mq, b_mv, b_err, b_fail;
    logic [1:0] b_ec, b_fc, b_st;
    logic [7:0] b_cc, b_ecnt;
    logic       c_mq, c_mv, c_err, c_fail;
    logic [1:0] c_ec, c_fc, c_st;
    logic [2:0] c_cc, c_ecnt;

    jk_ff_monitor u_a (
        .clk(clk), .clr(clr), .en(en), .j(j), .k(k), .dut_clr(dut_clr),
        .dut_preset(dut_preset), .q(q), .qbar(qbar), .model_q(a_mq), .model_vld(a_mv),
        .err(a_err), .err_code(a_ec), .first_code(a_fc), .fail(a_fail),
        .chk_cnt(a_cc), .err_cnt(a_ecnt), .state(a_st)
    );

    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) u_b (
        .clk(clk), .clr(clr), .en(en), .j(j), .k(k), .dut_clr(dut_clr),
        .dut_preset(dut_preset), .q(q), .qbar(qbar), .model_q(b_mq), .model_vld(b_mv),
        .err(b_err), .err_code(b_ec), .first_code(b_fc), .fail(b_fail),
        .chk_cnt(b_cc), .err_cnt(b_ecnt), .state(b_st)
    );

    jk_ff_monitor #(.CNT_W(3), .STOP_ON_ERR(1'b0)) u_c (
        .clk(clk), .clr(clr), .en(en), .j(j), .k(k), .dut_clr(dut_clr),
        .dut_preset(dut_preset), .q(q), .qbar(qbar), .model_q(c_mq), .model_vld(c_mv),
        .err(c_err), .err_code(c_ec), .first_code(c_fc), .fail(c_fail),
        .chk_cnt(c_cc), .err_cnt(c_ecnt), .state(c_st)
    );

    typedef struct {
        int          inst;
        logic [25:0] vec;   // {state, model_q, model_vld, err, err_code, fail, first_code, chk_cnt, err_cnt}
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the outputs expected after the coming edge for one instance.
    task automatic push_exp(input int inst, input logic [1:0] st, input logic mq, input logic mv,
                            input logic e, input logic [1:0] ec, input logic fl,
                            input logic [1:0] fc, input int cc, input int ecnt, input string name);
        exp_t it;
        logic [7:0] cc8, ec8;
        cc8 = cc[7:0];
        ec8 = ecnt[7:0];
        it.inst = inst;
        it.vec  = {st, mq, mv, e, ec, fl, fc, cc8, ec8};
        it.name = name;
        sb_q.push_back(it);
    endtask

    // One stimulus cycle: drive the observed flop at the falling edge, queue expectation.
    task automatic cyc(input logic en_i, input logic j_i, input logic k_i, input logic dc_i,
                       input logic dp_i, input logic q_i, input logic qb_i,
                       input int inst, input logic [1:0] st, input logic mq, input logic mv,
                       input logic e, input logic [1:0] ec, input logic fl, input logic [1:0] fc,
                       input int cc, input int ecnt, input string name);
        @(negedge clk);
        en = en_i; j = j_i; k = k_i; dut_clr = dc_i; dut_preset = dp_i; q = q_i; qbar = qb_i;
        push_exp(inst, st, mq, mv, e, ec, fl, fc, cc, ecnt, name);
    endtask

    // Assert monitor reset for one cycle (all outputs must read zero), then release.
    task automatic rst_cyc(input int inst, input string name);
        @(negedge clk);
        clr = 1'b0; en = 1'b0; j = 1'b0; k = 1'b0;
        dut_clr = 1'b1; dut_preset = 1'b1; q = 1'b0; qbar = 1'b1;
        push_exp(inst, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, name);
        @(negedge clk);
        clr = 1'b1;
    endtask

    // Monitor: after each rising edge, pop one expectation and compare.
    initial begin
        exp_t        it;
        logic [25:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.inst)
                    0:       act = {a_st, a_mq, a_mv, a_err, a_ec, a_fail, a_fc, a_cc, a_ecnt};
                    1:       act = {b_st, b_mq, b_mv, b_err, b_ec, b_fail, b_fc, b_cc, b_ecnt};
                    default: act = {c_st, c_mq, c_mv, c_err, c_ec, c_fail, c_fc,
                                    5'd0, c_cc, 5'd0, c_ecnt};
                endcase
                tests_run++;
                if (act !== it.vec) begin
                    tests_failed++;
                    $display("FAIL %s: got st=%b mq=%b mv=%b err=%b code=%b fail=%b first=%b chk=%0d errs=%0d, want st=%b mq=%b mv=%b err=%b code=%b fail=%b first=%b chk=%0d errs=%0d",
                             it.name, act[25:24], act[23], act[22], act[21], act[20:19], act[18],
                             act[17:16], act[15:8], act[7:0], it.vec[25:24], it.vec[23], it.vec[22],
                             it.vec[21], it.vec[20:19], it.vec[18], it.vec[17:16], it.vec[15:8],
                             it.vec[7:0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] q_tr, m_tr;
        q_tr = 8'b1000_1000;   // q the flop shows at each jk edge (bit i = edge i)
        m_tr = 8'b0100_0100;   // model state after each jk edge
        clr = 1'b0; en = 1'b0; j = 1'b0; k = 1'b0;
        dut_clr = 1'b1; dut_preset = 1'b1; q = 1'b0; qbar = 1'b1;

        // Default instance: reset, sync via dut_clr, clean JK trace.
        rst_cyc(0, "a_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "a_sync");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "a_load");
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, ((i % 4) >= 2), ((i % 2) == 1), 1'b1, 1'b1, q_tr[i], ~q_tr[i],
                0, 2'b10, m_tr[i], 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, i + 1, 0, "a_jk_trace");
        end
        // jk=11 held but q stuck at 1: every other edge disagrees.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b10, ((i % 2) == 0), 1'b1,
                ((i % 2) == 0), (((i % 2) == 0) ? 2'b01 : 2'b00), 1'b1, 2'b01, 9 + i, (i / 2) + 1,
                "a_toggle_miss");
        end
        // qbar faults, forced clear/preset, then en drop and resync.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b01, 13, 3, "a_q_qbar_high");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 14, 3, "a_clean1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01, 15, 4, "a_qbar_only");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 16, 4, "a_clean2");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 17, 4, "a_clr_and_preset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 18, 4, "a_preset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 19, 4, "a_hold_one");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 19, 4, "a_en_off");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 19, 4, "a_resync");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 19, 4, "a_reload");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b01, 20, 4, "a_k_reset");

        // STOP_ON_ERR instance: first error freezes everything in FAIL.
        rst_cyc(1, "b_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "b_sync");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "b_load");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1, 0, "b_clean");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b01, 2, 1, "b_stop");
        for (int i = 0; i < 20; i++) begin
            cyc((i != 5), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 2'b11, 1'b0, 1'b1, 1'b0, 2'b00,
                1'b1, 2'b01, 2, 1, "b_frozen");
        end

        // CNT_W=3 instance: both counters saturate, err still pulses, then mid-run reset.
        rst_cyc(2, "c_reset");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "c_sync");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 0, 0, "c_load");
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2'b10, 1'b0, 1'b1, 1'b0, 2'b00,
                1'b0, 2'b00, ((i < 7) ? i + 1 : 7), 0, "c_chk_sat");
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 2'b10, 1'b0, 1'b1, 1'b1, 2'b11,
                1'b1, 2'b11, 7, ((i < 7) ? i + 1 : 7), "c_err_sat");
        end
        rst_cyc(2, "c_mid_clr");

        // Drain the scoreboard with a bounded wait.
        for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
